// File: rtl/elevator_request_queue_pkg.sv
// Shared elevator constants, scan FSM state type and a popcount helper.
// Used by the request queue and by the destination resolver.
package elevator_pkg;

  localparam int NUM_FLOORS   = 7;
  localparam int FLOOR_W      = 3;
  localparam int SCAN_TIMEOUT = 15;
  localparam int CNT_W        = $clog2(SCAN_TIMEOUT + 1);

  localparam logic [FLOOR_W-1:0] FLOOR_NONE = 3'b111;

  typedef enum logic [1:0] {IDLE, START, WAIT} rq_state_t;

  function automatic logic [FLOOR_W-1:0] popcount(input logic [NUM_FLOORS-1:0] v);
    logic [FLOOR_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      c = c + FLOOR_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/elevator_request_queue_if.sv
// Button/serve inputs and queue_status outputs of the request queue.
// The slave modport is the queue itself; master is the car environment.
interface elevator_request_queue_if;
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] hall_call;
  logic [NUM_FLOORS-1:0] car_call;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  floor_served;
  logic                  resolve_done;
  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] queue_status;
  logic                  resolve_start;
  logic [FLOOR_W-1:0]    request_count;
  logic                  queue_empty;
  logic                  scan_error;

  modport master (
    output hall_call, car_call, current_floor, floor_served, resolve_done,
    input  pending, queue_status, resolve_start, request_count, queue_empty, scan_error
  );

  modport slave (
    input  hall_call, car_call, current_floor, floor_served, resolve_done,
    output pending, queue_status, resolve_start, request_count, queue_empty, scan_error
  );

endinterface

// File: rtl/elevator_request_queue_call_edge.sv
// Per-floor rising-edge detector on the combined button level.
// A button already held when reset releases counts as a fresh press.
module elevator_call_edge
  import elevator_pkg::*;
#(
  parameter int WIDTH = NUM_FLOORS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= level;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign press[gi] = level[gi] & ~r_prev[gi];
    end
  endgenerate

endmodule

// File: rtl/elevator_request_queue.sv
// Floor request register with a start/done scan handshake toward the resolver.
// queue_status only moves on the IDLE->START load, so the resolver sees a frozen set.
module elevator_request_queue
  import elevator_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  elevator_request_queue_if.slave  bus
);

  logic [NUM_FLOORS-1:0] w_level;
  logic [NUM_FLOORS-1:0] w_press;
  logic [NUM_FLOORS-1:0] w_clear;
  logic [NUM_FLOORS-1:0] w_pending_next;
  logic                  w_changed;

  rq_state_t             r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] r_queue_status;
  logic                  r_dirty;
  logic                  r_resolve_start;
  logic                  r_scan_error;
  logic [CNT_W-1:0]      r_cnt;

  assign w_level = bus.hall_call | bus.car_call;

  elevator_call_edge #(.WIDTH(NUM_FLOORS)) u_edge (
    .clk   (clk),
    .reset (reset),
    .level (w_level),
    .press (w_press)
  );

  // Clear beats set on the same floor: the doors are already open there.
  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_req
      assign w_clear[gi] = bus.floor_served
                         && (bus.current_floor != FLOOR_NONE)
                         && (bus.current_floor == FLOOR_W'(gi));
      assign w_pending_next[gi] = ~w_clear[gi] & (r_pending[gi] | w_press[gi]);
    end
  endgenerate

  assign w_changed = (w_pending_next != r_pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_pending       <= '0;
      r_queue_status  <= '0;
      r_dirty         <= 1'b0;
      r_resolve_start <= 1'b0;
      r_scan_error    <= 1'b0;
      r_cnt           <= '0;
    end else begin
      r_pending       <= w_pending_next;
      r_resolve_start <= 1'b0;
      // A change in the same cycle as the load keeps dirty set for a rescan.
      r_dirty         <= w_changed | (r_dirty & (r_state != IDLE));
      case (r_state)
        IDLE: begin
          if (r_dirty) begin
            r_queue_status  <= r_pending;
            r_resolve_start <= 1'b1;
            r_state         <= START;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt != CNT_W'(SCAN_TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (bus.resolve_done) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(SCAN_TIMEOUT)) begin
            r_scan_error <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pending       = r_pending;
  assign bus.queue_status  = r_queue_status;
  assign bus.resolve_start = r_resolve_start;
  assign bus.scan_error    = r_scan_error;
  assign bus.request_count = popcount(r_pending);
  assign bus.queue_empty   = (r_pending == '0);

endmodule
